// File: rtl/instr_fetch_unit.sv
// Sequential LEGv8 instruction-fetch front end: PC register, request/response fetch FSM, retire counter.
// Optional misaligned-PC fault enabled by defining FETCH_ALIGN_CHECK_EN.
module instr_fetch_unit #(
    parameter logic [63:0] RESET_PC   = 64'h0,
    parameter logic [31:0] COUNT_INIT = 32'h0
) (
    input  logic        CLK,
    input  logic        resetl,
    input  logic [63:0] NextPC,
    input  logic        Advance,
    output logic [63:0] CurrentPC,
    output logic [31:0] Instruction,
    output logic        InstrValid,
    output logic        IMemReqValid,
    input  logic        IMemReqReady,
    output logic [63:0] IMemAddr,
    input  logic        IMemRespValid,
    input  logic [31:0] IMemRespData,
    output logic [31:0] FetchCount,
    output logic        FetchFault
);

    typedef enum logic [1:0] {
        REQ   = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        FAULT = 2'd3
    } fetchState_t;

    fetchState_t state;

    function automatic logic isMisaligned(input logic [63:0] pc);
        return pc[1:0] != 2'b00;
    endfunction

    function automatic fetchState_t retireTarget(input logic [63:0] pc);
`ifdef FETCH_ALIGN_CHECK_EN
        return isMisaligned(pc) ? FAULT : REQ;
`else
        return (isMisaligned(pc) && 1'b0) ? FAULT : REQ;
`endif
    endfunction

    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            state       <= REQ;
            CurrentPC   <= RESET_PC;
            Instruction <= 32'h0;
            FetchCount  <= COUNT_INIT;
        end else begin
            case (state)
                REQ: begin
                    if (IMemReqReady)
                        state <= WAIT;
                end
                WAIT: begin
                    if (IMemRespValid) begin
                        Instruction <= IMemRespData;
                        state       <= HOLD;
                    end
                end
                HOLD: begin
                    // The retiring PC is loaded even when it faults, so the bad target is visible.
                    if (Advance) begin
                        CurrentPC  <= NextPC;
                        FetchCount <= FetchCount + 32'd1;
                        state      <= retireTarget(NextPC);
                    end
                end
                FAULT: state <= FAULT;
                default: state <= REQ;
            endcase
        end
    end

    assign IMemReqValid = (state == REQ);
    assign IMemAddr     = CurrentPC;
    assign InstrValid   = (state == HOLD);

`ifdef FETCH_ALIGN_CHECK_EN
    assign FetchFault = (state == FAULT);
`else
    assign FetchFault = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: fetch handshake, retire, stalls, reset mid-fetch, count wrap, alignment.
module tb_instr_fetch_unit;

    logic        CLK = 1'b0;
    logic        resetl;
    logic [63:0] NextPC;
    logic        Advance;
    logic [63:0] CurrentPC;
    logic [31:0] Instruction;
    logic        InstrValid;
    logic        IMemReqValid;
    logic        IMemReqReady;
    logic [63:0] IMemAddr;
    logic        IMemRespValid;
    logic [31:0] IMemRespData;
    logic [31:0] FetchCount;
    logic        FetchFault;

    logic        wResetl;
    logic        wAdvance;
    logic [63:0] wCurrentPC;
    logic [31:0] wInstruction;
    logic        wInstrValid;
    logic        wReqValid;
    logic [63:0] wAddr;
    logic [31:0] wFetchCount;
    logic        wFetchFault;

    int errors = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    instr_fetch_unit #(.RESET_PC(64'h0)) dut (
        .CLK          (CLK),
        .resetl       (resetl),
        .NextPC       (NextPC),
        .Advance      (Advance),
        .CurrentPC    (CurrentPC),
        .Instruction  (Instruction),
        .InstrValid   (InstrValid),
        .IMemReqValid (IMemReqValid),
        .IMemReqReady (IMemReqReady),
        .IMemAddr     (IMemAddr),
        .IMemRespValid(IMemRespValid),
        .IMemRespData (IMemRespData),
        .FetchCount   (FetchCount),
        .FetchFault   (FetchFault)
    );

    // Second instance starts its retire counter one short of wrapping.
    instr_fetch_unit #(.RESET_PC(64'h100), .COUNT_INIT(32'hFFFF_FFFF)) wrapDut (
        .CLK          (CLK),
        .resetl       (wResetl),
        .NextPC       (64'h104),
        .Advance      (wAdvance),
        .CurrentPC    (wCurrentPC),
        .Instruction  (wInstruction),
        .InstrValid   (wInstrValid),
        .IMemReqValid (wReqValid),
        .IMemReqReady (1'b1),
        .IMemAddr     (wAddr),
        .IMemRespValid(1'b1),
        .IMemRespData (32'h8B02_0020),
        .FetchCount   (wFetchCount),
        .FetchFault   (wFetchFault)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        resetl        = 1'b0;
        wResetl       = 1'b0;
        wAdvance      = 1'b0;
        NextPC        = 64'h0;
        Advance       = 1'b0;
        IMemReqReady  = 1'b0;
        IMemRespValid = 1'b0;
        IMemRespData  = 32'h0;
        tick();
        tick();

        check("rstPC", CurrentPC, 64'h0);
        check("rstInstr", Instruction, 32'h0);
        check("rstInstrValid", InstrValid, 1'b0);
        check("rstCount", FetchCount, 32'h0);
        check("rstFault", FetchFault, 1'b0);
        check("rstReqValid", IMemReqValid, 1'b1);
        check("rstAddr", IMemAddr, 64'h0);

        // First fetch: request accepted, response next cycle.
        resetl       = 1'b1;
        IMemReqReady = 1'b1;
        tick();
        check("waitReqValid", IMemReqValid, 1'b0);
        check("waitInstrValid", InstrValid, 1'b0);
        IMemReqReady  = 1'b0;
        IMemRespValid = 1'b1;
        IMemRespData  = 32'hF840_03E9;
        tick();
        IMemRespValid = 1'b0;
        check("holdInstrValid", InstrValid, 1'b1);
        check("holdInstr", Instruction, 32'hF840_03E9);
        check("holdPC", CurrentPC, 64'h0);
        check("holdReqValid", IMemReqValid, 1'b0);
        tick();
        check("holdStableValid", InstrValid, 1'b1);
        check("holdStableInstr", Instruction, 32'hF840_03E9);

        // Retire to 0x10.
        Advance = 1'b1;
        NextPC  = 64'h10;
        tick();
        Advance = 1'b0;
        check("advPC", CurrentPC, 64'h10);
        check("advReqValid", IMemReqValid, 1'b1);
        check("advAddr", IMemAddr, 64'h10);
        check("advCount", FetchCount, 32'd1);
        check("advInstrValid", InstrValid, 1'b0);

        // Stall five cycles with ready low; spurious response and stray Advance.
        for (int i = 0; i < 5; i++) begin
            IMemRespValid = (i == 1);
            IMemRespData  = 32'hDEAD_BEEF;
            Advance       = (i == 2);
            NextPC        = 64'h40;
            tick();
            check("stallReqValid", IMemReqValid, 1'b1);
            check("stallAddr", IMemAddr, 64'h10);
        end
        IMemRespValid = 1'b0;
        Advance       = 1'b0;
        check("spuriousInstr", Instruction, 32'hF840_03E9);
        check("strayAdvPC", CurrentPC, 64'h10);
        check("strayAdvCount", FetchCount, 32'd1);

        // Reset while in WAIT; the late response must be discarded.
        IMemReqReady = 1'b1;
        tick();
        IMemReqReady = 1'b0;
        check("preRstWait", IMemReqValid, 1'b0);
        resetl = 1'b0;
        #1;
        check("asyncRstPC", CurrentPC, 64'h0);
        check("asyncRstCount", FetchCount, 32'h0);
        check("asyncRstReqValid", IMemReqValid, 1'b1);
        tick();
        resetl        = 1'b1;
        IMemRespValid = 1'b1;
        IMemRespData  = 32'h1234_5678;
        tick();
        IMemRespValid = 1'b0;
        check("lateRespValid", InstrValid, 1'b0);
        check("lateRespInstr", Instruction, 32'h0);
        check("lateRespReq", IMemReqValid, 1'b1);
        check("lateRespAddr", IMemAddr, 64'h0);

        // Fetch and retire to a full-width 64-bit target.
        IMemReqReady = 1'b1;
        tick();
        IMemReqReady  = 1'b0;
        IMemRespValid = 1'b1;
        IMemRespData  = 32'hAAAA_5555;
        tick();
        IMemRespValid = 1'b0;
        check("instr2", Instruction, 32'hAAAA_5555);
        Advance = 1'b1;
        NextPC  = 64'h8000_0000_0000_1000;
        tick();
        Advance = 1'b0;
        check("widePC", CurrentPC, 64'h8000_0000_0000_1000);
        check("wideAddr", IMemAddr, 64'h8000_0000_0000_1000);

        // Fetch then retire to a misaligned target.
        IMemReqReady = 1'b1;
        tick();
        IMemReqReady  = 1'b0;
        IMemRespValid = 1'b1;
        IMemRespData  = 32'h0123_4567;
        tick();
        IMemRespValid = 1'b0;
        check("instr3", Instruction, 32'h0123_4567);
        Advance = 1'b1;
        NextPC  = 64'h6;
        tick();
        Advance = 1'b0;
        check("misPC", CurrentPC, 64'h6);
        check("misCount", FetchCount, 32'd2);
`ifdef FETCH_ALIGN_CHECK_EN
        check("misFault", FetchFault, 1'b1);
        IMemReqReady = 1'b1;
        for (int i = 0; i < 10; i++) begin
            Advance = 1'b1;
            NextPC  = 64'h20;
            tick();
            check("faultReqValid", IMemReqValid, 1'b0);
            check("faultSticky", FetchFault, 1'b1);
        end
        Advance      = 1'b0;
        IMemReqReady = 1'b0;
        check("faultPC", CurrentPC, 64'h6);
        check("faultCount", FetchCount, 32'd2);
`else
        check("misFault", FetchFault, 1'b0);
        check("misAddr", IMemAddr, 64'h6);
        check("misReqValid", IMemReqValid, 1'b1);
`endif

        // Retire counter wrap on the preloaded instance.
        wResetl = 1'b1;
        tick();
        tick();
        check("wrapHold", wInstrValid, 1'b1);
        check("wrapPre", wFetchCount, 32'hFFFF_FFFF);
        wAdvance = 1'b1;
        tick();
        wAdvance = 1'b0;
        check("wrapCount", wFetchCount, 32'h0);
        check("wrapPC", wCurrentPC, 64'h104);
        check("wrapFault", wFetchFault, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
